// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared target-state type and default game constants
package game_pkg;

  typedef enum logic [1:0] {
    ALIVE,
    INVULN,
    DEFEATED
  } target_state_t;

  localparam int DEFAULT_TARGETS = 4;
  localparam int DEFAULT_BOSS_HP = 10;
  localparam int DEFAULT_IFRAMES = 8;

endpackage

// File: rtl/hit_channel.sv
// rtl/hit_channel.sv - one target: hit edge detect, i-frame cooldown, saturating count, defeat
module hit_channel
  import game_pkg::*;
#(
  parameter int HP       = DEFAULT_BOSS_HP,
  parameter int COOLDOWN = DEFAULT_IFRAMES,
  localparam int CW      = $clog2(HP + 1),
  localparam int TW      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          frame_tick,
  input  logic          hit,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          invuln,
  output logic          defeated,
  output logic          defeated_pulse
);

  localparam logic [CW-1:0] LAST_HIT = CW'(HP - 1);
  localparam logic [CW-1:0] FULL     = CW'(HP);
  localparam logic [TW-1:0] CD_LOAD  = TW'(COOLDOWN);
  localparam logic [TW-1:0] CD_ONE   = TW'(1);

  target_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] cd_q, cd_d;
  logic          prev_hit_q;
  logic          pulse_q, pulse_d;
  logic          rise;

  assign rise = hit & ~prev_hit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ALIVE;
      count_q    <= '0;
      cd_q       <= '0;
      prev_hit_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cd_q       <= cd_d;
      prev_hit_q <= hit;
      pulse_q    <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cd_d    = cd_q;
    pulse_d = 1'b0;
    if (clear) begin
      state_d = ALIVE;
      count_d = '0;
      cd_d    = '0;
    end else begin
      case (state_q)
        ALIVE: begin
          if (rise) begin
            if (count_q == LAST_HIT) begin
              count_d = FULL;
              state_d = DEFEATED;
              pulse_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
              if (COOLDOWN > 0) begin
                state_d = INVULN;
                cd_d    = CD_LOAD;
              end
            end
          end
        end
        // Rises during i-frames are dropped, including on the tick that ends them.
        INVULN: begin
          if (frame_tick) begin
            cd_d = cd_q - 1'b1;
            if (cd_q == CD_ONE) state_d = ALIVE;
          end
        end
        DEFEATED: ;
        default: state_d = ALIVE;
      endcase
    end
  end

  assign count          = count_q;
  assign invuln         = (state_q == INVULN);
  assign defeated       = (state_q == DEFEATED);
  assign defeated_pulse = pulse_q;

endmodule

// File: rtl/multi_target_hit_tracker.sv
// rtl/multi_target_hit_tracker.sv - NUM_TARGETS independent hit channels with packed outputs
module multi_target_hit_tracker
  import game_pkg::*;
#(
  parameter int NUM_TARGETS = DEFAULT_TARGETS,
  parameter int HP          = DEFAULT_BOSS_HP,
  parameter int COOLDOWN    = DEFAULT_IFRAMES,
  localparam int CW         = $clog2(HP + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      frame_tick,
  input  logic [NUM_TARGETS-1:0]    hit,
  input  logic [NUM_TARGETS-1:0]    clear,
  output logic [NUM_TARGETS*CW-1:0] count,
  output logic [NUM_TARGETS-1:0]    invuln,
  output logic [NUM_TARGETS-1:0]    defeated,
  output logic [NUM_TARGETS-1:0]    defeated_pulse
);

  for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_ch
    hit_channel #(
      .HP       (HP),
      .COOLDOWN (COOLDOWN)
    ) u_ch (
      .clk            (clk),
      .reset_n        (reset_n),
      .frame_tick     (frame_tick),
      .hit            (hit[i]),
      .clear          (clear[i]),
      .count          (count[i*CW +: CW]),
      .invuln         (invuln[i]),
      .defeated       (defeated[i]),
      .defeated_pulse (defeated_pulse[i])
    );
  end

endmodule

// File: doc/multi_target_hit_tracker.md
Name: multi_target_hit_tracker

Overview:
Parametrised successor to the single-boss hit counter. Tracks hits on NUM_TARGETS independent targets (boss phases, enemies). Each target has rising-edge hit detection, a frame-based invulnerability window, a saturating hit count, and defeat detection.
Sits between the bullet/target collision logic and the game-state FSM / score and sprite logic.

Parameters:
NUM_TARGETS, 4, number of independent target channels (>=1)
HP, 10, hits required to defeat a target (>=1)
COOLDOWN, 8, frame ticks of invulnerability after a non-fatal accepted hit (0 = no invulnerability)
CW, $clog2(HP+1), derived count width (localparam, not overridable)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame; advances cooldown timers
hit  in  NUM_TARGETS  per-target collision level from the collision detector
clear  in  NUM_TARGETS  per-target respawn: zero count, return to ALIVE
count  out  NUM_TARGETS*CW  packed hit counts; target i in bits [i*CW +: CW]
invuln  out  NUM_TARGETS  target i is in INVULN state
defeated  out  NUM_TARGETS  target i is in DEFEATED state (level)
defeated_pulse  out  NUM_TARGETS  one-cycle pulse on entry to DEFEATED

Behaviour:
- Clock and reset: one clock is used. Reset is asynchronous and active-low. While reset_n=0, for every channel: count=0, prev_hit=0, cooldown=0, state=ALIVE, invuln=0, defeated=0, defeated_pulse=0.
- Edge detection: rise_i = hit[i] & ~prev_hit[i]. prev_hit[i] <= hit[i] every cycle, in every state, including clear cycles. A held hit never produces a second rise.
- Per-channel FSM has three states: ALIVE, INVULN, DEFEATED.
- ALIVE, rise_i, count < HP-1: count increments. If COOLDOWN > 0, go to INVULN with cooldown = COOLDOWN; otherwise stay in ALIVE.
- ALIVE, rise_i, count == HP-1: count becomes HP and the channel goes to DEFEATED. defeated_pulse is high for exactly the next cycle. Cooldown is not loaded.
- INVULN: rises are discarded (count unchanged). On frame_tick, cooldown decrements. A frame_tick that takes cooldown from 1 to 0 returns the channel to ALIVE on the following cycle.
- A rise in the same cycle as the INVULN-to-ALIVE transition is discarded.
- DEFEATED: sticky. Rises are ignored. count holds at HP. Only clear or reset leaves this state.
- clear[i] has priority over rise_i and frame_tick in the same cycle. It sets count=0, cooldown=0, state=ALIVE. A hit that is high during clear and stays high is not counted.
- Latency: a rise sampled at edge n is visible on count, invuln and defeated after edge n (one register stage). defeated_pulse is asserted in the cycle right after that edge.
- Arithmetic: count never exceeds HP and never wraps. Cooldown width is $clog2(COOLDOWN+1), with a minimum of 1.
- Channels are fully independent. Simultaneous rises on several channels are each processed in the same cycle.
- Reset mid-operation (mid-INVULN or mid-DEFEATED) returns the channel to the reset values immediately, asynchronously.
- frame_tick while in ALIVE or DEFEATED has no effect.

Decomposition:
- Package game_pkg holds:
  - typedef enum logic [1:0] {ALIVE, INVULN, DEFEATED} target_state_t
  - shared constants DEFAULT_BOSS_HP and DEFAULT_IFRAMES, used by the top level when instantiating.
- Sub-module hit_channel holds one target's edge detector, FSM, cooldown counter and count. It takes parameters HP and COOLDOWN.
- multi_target_hit_tracker is a generate loop of NUM_TARGETS hit_channel instances plus output packing.

Test Plan:
All scenarios use NUM_TARGETS=2, HP=3, COOLDOWN=2.
1. Reset: drive reset_n=0 mid-run with count[0]=2 and target 0 in INVULN -> count=0, invuln=0, defeated=0 immediately, without waiting for a clock edge.
2. Edge detection and invulnerability:
   - hit[0] held high for 5 cycles, then a second pulse before any frame_tick -> count[0]=1, invuln[0]=1; the second pulse is ignored.
   - Then 2 frame_ticks -> invuln[0]=0.
   - Then a new hit pulse -> count[0]=2.
3. Defeat: three accepted hits on target 0, with frame_ticks between them -> count[0]=3, defeated[0]=1, defeated_pulse[0] high for exactly 1 cycle. A further hit pulse leaves count[0]=3.
4. Channel independence and simultaneity: hit rising on both channels in the same cycle -> count[0]=1 and count[1]=1, both invuln=1 on the next cycle. A frame_tick affects both channels.
5. Clear priority: clear[1] asserted in the same cycle as a hit[1] rise, with count[1]=2 -> count[1]=0, state ALIVE, hit not counted. hit[1] still held after clear drops -> count stays 0 until hit falls and rises again.
6. COOLDOWN=0 variant: two hit pulses separated by one low cycle -> count=2, invuln never asserts.
